// File: rtl/uart_csr_arbiter.sv
// uart_csr_arbiter: arbitrates N_REQ CSR requesters onto a single CSR read/write port.
//
// Package uart_csr_pkg (in this file) defines uart_csr_addr_t, uart_csr_data_t and the CSR address map.
//
// Optional feature macro: UART_CSR_ARB_RR_EN
//   defined   -> round-robin arbitration
//   undefined -> fixed priority, lowest index wins
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   req_valid/req_wr      per-requester pending access and type (1 = write)
//   req_addr/req_wdata    per-requester address and write data
//   req_ready             one-cycle accept pulse to the granted requester
//   rsp_valid/rsp_rdata   one-cycle completion pulse to the owner, read data (0 for writes)
//   wen/wr_addr/wr_data   CSR write port
//   ren/rd_addr           CSR read request port
//   rd_data               CSR read data, valid one cycle after ren
package uart_csr_pkg;
    typedef logic [7:0]  uart_csr_addr_t;
    typedef logic [31:0] uart_csr_data_t;
    localparam uart_csr_addr_t UART_CONTROL_0_CSR_ADDR = 8'h00;
    localparam uart_csr_addr_t UART_STATUS_0_CSR_ADDR  = 8'h04;
    localparam uart_csr_addr_t UART_BAUD_RATE_CSR_ADDR = 8'h08;
endpackage

module uart_csr_arbiter
    import uart_csr_pkg::*;
#(
    parameter int N_REQ = 2
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic           [N_REQ-1:0]       req_valid,
    input  logic           [N_REQ-1:0]       req_wr,
    input  uart_csr_addr_t [N_REQ-1:0]       req_addr,
    input  uart_csr_data_t [N_REQ-1:0]       req_wdata,
    output logic           [N_REQ-1:0]       req_ready,
    output logic           [N_REQ-1:0]       rsp_valid,
    output uart_csr_data_t                   rsp_rdata,
    output logic                             wen,
    output uart_csr_addr_t                   wr_addr,
    output uart_csr_data_t                   wr_data,
    output logic                             ren,
    output uart_csr_addr_t                   rd_addr,
    input  uart_csr_data_t                   rd_data
);
    localparam int IDX_W = $clog2(N_REQ);

    typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

    state_t         state, state_nxt;
    logic           cmd_wr;
    uart_csr_addr_t cmd_addr;
    uart_csr_data_t cmd_wdata;
    logic [IDX_W-1:0] cmd_idx;
    logic [IDX_W-1:0] win;
    logic           found;
    logic           grant;
    int             j;
`ifdef UART_CSR_ARB_RR_EN
    logic [IDX_W-1:0] ptr;
`endif

    // rst_n gates the grant so req_ready cannot pulse while reset is held
    assign grant = rst_n && state == IDLE && |req_valid;

    always_comb begin
        win   = '0;
        found = 1'b0;
        j     = 0;
        for (int k = 0; k < N_REQ; k++) begin
`ifdef UART_CSR_ARB_RR_EN
            j = (int'(ptr) + k) % N_REQ;
`else
            j = k;
`endif
            if (!found && req_valid[j]) begin
                win   = IDX_W'(j);
                found = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = IDLE;
        case (state)
            IDLE:    state_nxt = grant ? ISSUE : IDLE;
            ISSUE:   state_nxt = RESP;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_wr    <= 1'b0;
            cmd_addr  <= '0;
            cmd_wdata <= '0;
            cmd_idx   <= '0;
        end else if (grant) begin
            cmd_wr    <= req_wr[win];
            cmd_addr  <= req_addr[win];
            cmd_wdata <= req_wdata[win];
            cmd_idx   <= win;
        end
    end

`ifdef UART_CSR_ARB_RR_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            ptr <= '0;
        else if (grant)
            ptr <= (win == IDX_W'(N_REQ - 1)) ? '0 : win + 1'b1;
    end
`endif

    always_comb begin
        req_ready = '0;
        rsp_valid = '0;
        if (grant)
            req_ready[win] = 1'b1;
        if (state == RESP)
            rsp_valid[cmd_idx] = 1'b1;
        wen       = state == ISSUE && cmd_wr;
        ren       = state == ISSUE && !cmd_wr;
        rsp_rdata = (state == RESP && !cmd_wr) ? rd_data : '0;
    end

    assign wr_addr = cmd_addr;
    assign rd_addr = cmd_addr;
    assign wr_data = cmd_wdata;
endmodule

// File: tb/tb_uart_csr_arbiter.sv
// tb_uart_csr_arbiter: directed self-checking bench for uart_csr_arbiter (N_REQ = 2).
module tb_uart_csr_arbiter;
    import uart_csr_pkg::*;

    logic                 clk;
    logic                 rst_n;
    logic           [1:0] req_valid;
    logic           [1:0] req_wr;
    uart_csr_addr_t [1:0] req_addr;
    uart_csr_data_t [1:0] req_wdata;
    logic           [1:0] req_ready;
    logic           [1:0] rsp_valid;
    uart_csr_data_t       rsp_rdata;
    logic                 wen;
    uart_csr_addr_t       wr_addr;
    uart_csr_data_t       wr_data;
    logic                 ren;
    uart_csr_addr_t       rd_addr;
    uart_csr_data_t       rd_data;

    int checks = 0;
    int errors = 0;
    int ren_cnt = 0;
    int ren_base;
    logic [1:0] exp_rdy;

    uart_csr_arbiter #(.N_REQ(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_wr(req_wr), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .wen(wen), .wr_addr(wr_addr), .wr_data(wr_data),
        .ren(ren), .rd_addr(rd_addr), .rd_data(rd_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // CSR block model: registered read data, one cycle after ren
    always @(posedge clk) begin
        if (ren) begin
            ren_cnt <= ren_cnt + 1;
            rd_data <= rd_addr == UART_CONTROL_0_CSR_ADDR ? 32'h5 :
                       rd_addr == UART_STATUS_0_CSR_ADDR  ? 32'h80 : 32'h0;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n     = 1'b0;
        req_valid = '0;
        req_wr    = '0;
        req_addr  = '0;
        req_wdata = '0;
        rd_data   = '0;
        #2;
        chk("rst_ready", 32'(req_ready), 0);
        chk("rst_rsp_valid", 32'(rsp_valid), 0);
        chk("rst_wen_ren", {30'd0, wen, ren}, 0);
        chk("rst_addr", {wr_addr, rd_addr}, 0);
        chk("rst_wdata", wr_data, 0);
        chk("rst_rdata", rsp_rdata, 0);
        tick;
        rst_n = 1'b1;
        tick;

        // single write from requester 0
        ren_base     = ren_cnt;
        req_valid    = 2'b01;
        req_wr       = 2'b01;
        req_addr[0]  = UART_BAUD_RATE_CSR_ADDR;
        req_wdata[0] = 32'h1B2;
        #1 chk("wr_ready_T", 32'(req_ready), 32'h1);
        tick;
        req_valid   = 2'b10;
        req_wr      = 2'b00;
        req_addr[1] = UART_CONTROL_0_CSR_ADDR;
        #1;
        chk("wr_wen_T1", {30'd0, wen, ren}, 32'h2);
        chk("wr_data_T1", wr_data, 32'h1B2);
        chk("wr_addr_T1", 32'(wr_addr), 32'(UART_BAUD_RATE_CSR_ADDR));
        chk("wr_busy_ready", 32'(req_ready), 0);
        tick;
        req_valid = 2'b00;
        #1;
        chk("wr_rsp_T2", 32'(rsp_valid), 32'h1);
        chk("wr_rdata_T2", rsp_rdata, 0);
        tick;
        tick;
        chk("withdraw_no_ren", 32'(ren_cnt - ren_base), 0);
        chk("withdraw_no_ready", 32'(req_ready), 0);

        // single read from requester 1
        ren_base    = ren_cnt;
        req_valid   = 2'b10;
        req_wr      = 2'b00;
        req_addr[1] = UART_CONTROL_0_CSR_ADDR;
        #1 chk("rd_ready_T", 32'(req_ready), 32'h2);
        tick;
        req_valid = 2'b00;
        #1;
        chk("rd_ren_T1", {30'd0, wen, ren}, 32'h1);
        chk("rd_addr_T1", 32'(rd_addr), 32'(UART_CONTROL_0_CSR_ADDR));
        tick;
        chk("rd_rsp_T2", 32'(rsp_valid), 32'h2);
        chk("rd_rdata_T2", rsp_rdata, 32'h5);
        chk("rd_no_ren_T2", {31'd0, ren}, 0);
        tick;
        chk("rd_rsp_done", 32'(rsp_valid), 0);
        chk("rd_ren_count", 32'(ren_cnt - ren_base), 1);

        // status read: exactly one ren pulse for the whole transaction
        ren_base    = ren_cnt;
        req_valid   = 2'b01;
        req_wr      = 2'b00;
        req_addr[0] = UART_STATUS_0_CSR_ADDR;
        #1 chk("st_ready_T", 32'(req_ready), 32'h1);
        tick;
        req_valid = 2'b00;
        tick;
        chk("st_rsp_T2", 32'(rsp_valid), 32'h1);
        chk("st_rdata_T2", rsp_rdata, 32'h80);
        repeat (3) tick;
        chk("st_ren_count", 32'(ren_cnt - ren_base), 1);

        // contention from a fresh reset: pointer starts at 0
        rst_n = 1'b0;
        tick;
        rst_n        = 1'b1;
        req_valid    = 2'b11;
        req_wr       = 2'b11;
        req_addr[0]  = UART_BAUD_RATE_CSR_ADDR;
        req_addr[1]  = UART_CONTROL_0_CSR_ADDR;
        for (int c = 0; c < 12; c++) begin
`ifdef UART_CSR_ARB_RR_EN
            exp_rdy = (c % 3 != 0) ? 2'b00 : ((c / 3) % 2 == 0) ? 2'b01 : 2'b10;
`else
            exp_rdy = (c % 3 != 0) ? 2'b00 : 2'b01;
`endif
            #1 chk($sformatf("cont_ready_c%0d", c), 32'(req_ready), 32'(exp_rdy));
            tick;
        end
        req_valid = 2'b00;
        repeat (3) tick;

        // reset while in ISSUE abandons the read
        req_valid   = 2'b10;
        req_wr      = 2'b00;
        req_addr[1] = UART_CONTROL_0_CSR_ADDR;
        #1 chk("rm_ready_T", 32'(req_ready), 32'h2);
        tick;
        req_valid = 2'b00;
        #1 chk("rm_ren_before", {31'd0, ren}, 1);
        rst_n = 1'b0;
        #1;
        chk("rm_strobes", {30'd0, wen, ren}, 0);
        chk("rm_addr", {wr_addr, rd_addr}, 0);
        chk("rm_outputs", {rsp_valid, req_ready}, 0);
        tick;
        tick;
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #1 chk($sformatf("rm_no_rsp_c%0d", c), 32'(rsp_valid), 0);
            tick;
        end
        req_valid = 2'b11;
        req_wr    = 2'b00;
        #1 chk("rm_first_grant", 32'(req_ready), 32'h1);
        tick;
        req_valid = 2'b00;
        repeat (3) tick;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/uart_csr_arbiter.md
UART_CSR_ARBITER -- requirements
Module: uart_csr_arbiter

Interface
REQ-001 Parameter N_REQ, default 2, SHALL set the number of CSR requesters; legal range is 2..8.
REQ-002 The clock SHALL be clk, a 1-bit input; all logic is rising-edge triggered.
REQ-003 The reset SHALL be rst_n, a 1-bit input, asynchronous, active-low.
REQ-004 req_valid  input  [N_REQ]  SHALL indicate that requester i holds a pending access.
REQ-005 req_wr  input  [N_REQ]  SHALL select the access type per requester: 1 = write, 0 = read.
REQ-006 req_addr  input  [N_REQ] x uart_csr_addr_t  SHALL carry the per-requester CSR address.
REQ-007 req_wdata  input  [N_REQ] x uart_csr_data_t  SHALL carry the per-requester write data.
REQ-008 req_ready  output  [N_REQ]  SHALL be a one-cycle accept pulse to the granted requester.
REQ-009 rsp_valid  output  [N_REQ]  SHALL be a one-cycle completion pulse to the owning requester.
REQ-010 rsp_rdata  output  uart_csr_data_t  SHALL carry the read data, qualified by rsp_valid.
REQ-011 wen, wr_addr, wr_data  outputs  1 / uart_csr_addr_t / uart_csr_data_t  SHALL form the CSR write port.
REQ-012 ren, rd_addr  outputs  1 / uart_csr_addr_t  SHALL form the CSR read request port.
REQ-013 rd_data  input  uart_csr_data_t  SHALL carry CSR read data, registered by the CSR block one cycle after ren.

Function
REQ-014 The FSM SHALL have three states: IDLE, ISSUE and RESP.
REQ-015 In IDLE with any req_valid set, the block SHALL pick a winner and assert req_ready[winner] combinationally in that cycle.
REQ-016 On that same edge the block SHALL latch the winner's req_wr, req_addr, req_wdata and index, and move to ISSUE.
REQ-017 In IDLE with no req_valid set, the block SHALL stay in IDLE with all req_ready low.
REQ-018 In ISSUE the block SHALL drive wen (write) or ren (read) high for exactly one cycle from the latched command, then move to RESP.
REQ-019 wr_addr, rd_addr and wr_data SHALL always reflect the latched command register; only wen and ren qualify them.
REQ-020 In RESP the block SHALL pulse rsp_valid[owner] for one cycle, then move to IDLE.
- For a read, rsp_rdata SHALL equal rd_data.
- For a write, rsp_rdata SHALL be 0.
REQ-021 Each accepted access SHALL produce exactly one wen or ren pulse, because status reads clear sticky error bits and a duplicated read loses error flags.
REQ-022 Latency SHALL be: grant at cycle T, CSR strobe at T+1, rsp_valid at T+2; the earliest next grant is T+3.
REQ-023 A requester SHALL hold valid and its fields stable until it sees req_ready; deasserting valid before grant SHALL withdraw the request with no side effects.
REQ-024 rsp_valid SHALL have no backpressure, and it SHALL never be asserted for a non-owner.
REQ-025 At most one bit of req_ready and one bit of rsp_valid SHALL be set in any cycle.
REQ-026 A req_valid change during ISSUE or RESP SHALL NOT affect the transaction in flight.

Reset
REQ-027 On rst_n low, the block SHALL immediately force:
- state = IDLE;
- req_ready, rsp_valid, wen, ren = 0;
- rsp_rdata, wr_addr, rd_addr, wr_data = 0;
- priority pointer = 0.
REQ-028 A reset during ISSUE or RESP SHALL abandon the transaction with no rsp_valid issued after reset release.
REQ-029 The first grant after reset SHALL favour requester 0.

Configuration
REQ-030 With UART_CSR_ARB_RR_EN defined, arbitration SHALL be round-robin.
- The search starts at pointer p.
- On each grant, p becomes (winner+1) mod N_REQ.
REQ-031 Without UART_CSR_ARB_RR_EN, arbitration SHALL be fixed priority with the lowest index winning, and no pointer state exists.

Verification
REQ-032 Single write: req 0 writes 0x1B2 to UART_BAUD_RATE_CSR_ADDR -> ready@T, wen=1 and wr_data=0x1B2 @T+1, rsp_valid[0]@T+2 with rsp_rdata=0.
REQ-033 Single read: req 1 reads UART_CONTROL_0_CSR_ADDR while the CSR returns 0x5 -> ren@T+1 only, rsp_valid[1]@T+2 with rsp_rdata=0x5.
REQ-034 Contention with RR_EN: req 0 and req 1 both valid continuously -> grants alternate 0,1,0,1 every 3 cycles.
REQ-035 Contention without RR_EN: the same stimulus -> req 0 is granted every 3 cycles and req 1 is starved.
REQ-036 Status read: req 0 reads UART_STATUS_0_CSR_ADDR -> exactly one ren pulse over the whole transaction.
REQ-037 Reset mid-operation: rst_n low in ISSUE -> all outputs go to 0 immediately, no rsp_valid after release, and the next grant goes to req 0.
